// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared types for the memory copy engine.
//   state_t : engine FSM encoding (IDLE, RD, WR, DONE), 2 bits
//   dir_t   : copy direction (FWD increments pointers, BWD decrements)
package mem_copy_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic {
      FWD = 1'b0,
      BWD = 1'b1
   } dir_t;

endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: overlap-safe (memmove) block copier driving a single-port
// memory with combinational read data. One read cycle and one write cycle per
// word; reports the M-bit wrap-around sum of the words written.
//
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   start              copy request, sampled only in IDLE
//   src, dst           source / destination base addresses (N bits)
//   len                word count 0..2**N (N+1 bits), larger values clamped
//   busy               high in RD/WR
//   done               one-cycle pulse when a copy completes (also len=0)
//   checksum           sum mod 2**M of the words written by the last copy
//   mem_addr           memory address
//   mem_wdata, mem_we  memory write data / write enable
//   mem_rdata          memory read data (combinational from mem_addr)
module mem_copy_engine
   import mem_copy_pkg::*;
#(
   parameter int M = 32,
   parameter int N = 10
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] src,
   input  logic [N-1:0] dst,
   input  logic [N:0]   len,
   output logic         busy,
   output logic         done,
   output logic [M-1:0] checksum,
   output logic [N-1:0] mem_addr,
   output logic [M-1:0] mem_wdata,
   output logic         mem_we,
   input  logic [M-1:0] mem_rdata
);

   localparam logic [N:0]   CNT_ONE = (N+1)'(1);
   localparam logic [N-1:0] PTR_ONE = N'(1);
   localparam logic [N:0]   MAX_LEN = CNT_ONE << N;

   state_t       state, next_state;
   dir_t         dir, dir_sel;
   logic [N-1:0] rptr, wptr;
   logic [N:0]   cnt;
   logic [M-1:0] data;

   logic [N:0]   len_clamp;
   logic [N-1:0] diff;
   logic [N-1:0] len_m1;

   // Request decode, only consumed in IDLE when start is accepted.
   // Backward mode is chosen when dst lies inside [src, src+len) modulo the
   // memory size, so the tail is copied first and no unread source word is
   // overwritten.
   always_comb begin
      len_clamp = (len > MAX_LEN) ? MAX_LEN : len;
      diff      = dst - src;
      len_m1    = len_clamp[N-1:0] - PTR_ONE;
      dir_sel   = ((dst != src) && ({1'b0, diff} < len_clamp)) ? BWD : FWD;
   end

   // Next state and memory-side outputs; everything idles at zero outside
   // RD/WR so the memory sees no stray addresses or writes.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (len_clamp == '0) ? DONE : RD;
            end
         end
         RD: begin
            busy       = 1'b1;
            mem_addr   = rptr;
            next_state = WR;
         end
         WR: begin
            busy       = 1'b1;
            mem_addr   = wptr;
            mem_wdata  = data;
            mem_we     = 1'b1;
            next_state = (cnt == CNT_ONE) ? DONE : RD;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         dir      <= FWD;
         rptr     <= '0;
         wptr     <= '0;
         cnt      <= '0;
         data     <= '0;
         checksum <= '0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (start) begin
                  cnt      <= len_clamp;
                  dir      <= dir_sel;
                  checksum <= '0;
                  if (dir_sel == BWD) begin
                     rptr <= src + len_m1;
                     wptr <= dst + len_m1;
                  end else begin
                     rptr <= src;
                     wptr <= dst;
                  end
               end
            end
            RD: begin
               data <= mem_rdata;
            end
            WR: begin
               checksum <= checksum + data;
               cnt      <= cnt - CNT_ONE;
               if (dir == BWD) begin
                  rptr <= rptr - PTR_ONE;
                  wptr <= wptr - PTR_ONE;
               end else begin
                  rptr <= rptr + PTR_ONE;
                  wptr <= wptr + PTR_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: self-checking bench for mem_copy_engine (M=8, N=4)
// with a behavioural single-port memory and a write scoreboard.
module tb_mem_copy_engine;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] src = '0;
   logic [3:0] dst = '0;
   logic [4:0] len = '0;
   logic       busy, done, mem_we;
   logic [7:0] checksum, mem_wdata, mem_rdata;
   logic [3:0] mem_addr;

   logic [7:0] mem [16];

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        exp_q[$];
   logic [3:0] wlog[$];
   int         checks   = 0;
   int         errors   = 0;
   int         cyc      = 0;
   int         we_cnt   = 0;
   int         done_cnt = 0;
   int         wbase    = 0;

   mem_copy_engine #(.M(8), .N(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .src       (src),
      .dst       (dst),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .checksum  (checksum),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   always #5 clock = ~clock;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (mem_we) mem[mem_addr] = mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer and bus invariants.
   always @(negedge clock) begin
      wr_t e;
      if (mem_we) begin
         we_cnt++;
         wlog.push_back(mem_addr);
         check("we_busy", busy, 1);
         check("write_pending", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("write_addr", mem_addr, e.addr);
            check("write_data", mem_wdata, e.data);
         end
      end
      if (done) done_cnt++;
      if (!busy) begin
         check("idle_we", mem_we, 0);
         check("idle_addr", mem_addr, 0);
         check("idle_wdata", mem_wdata, 0);
      end
   end

   // Reference: word-by-word memmove on a copy of the memory, pushing every
   // expected write; then run the copy and check timing and totals.
   task automatic run_copy(input logic [3:0] s, input logic [3:0] d,
                           input logic [4:0] l, input bit mid_start);
      logic [7:0] mm [16];
      logic [3:0] ra, wa, diff;
      logic [7:0] v, sum;
      int         L, c0, k, we0, dn0;
      bit         bwd;
      mm   = mem;
      L    = (l > 16) ? 16 : int'(l);
      diff = d - s;
      bwd  = (d != s) && (int'(diff) < L);
      sum  = '0;
      for (int i = 0; i < L; i++) begin
         ra = bwd ? 4'(int'(s) + L - 1 - i) : 4'(int'(s) + i);
         wa = bwd ? 4'(int'(d) + L - 1 - i) : 4'(int'(d) + i);
         v  = mm[ra];
         mm[wa] = v;
         exp_q.push_back('{addr: wa, data: v});
         sum += v;
      end
      we0   = we_cnt;
      dn0   = done_cnt;
      wbase = wlog.size();
      src   = s;
      dst   = d;
      len   = l;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      c0    = cyc;
      k     = 0;
      while (!done && k < 100) begin
         check("busy_during", busy, 1);
         start = mid_start && (k == 2);
         @(negedge clock);
         k++;
      end
      start = 1'b0;
      check("done_seen", done, 1);
      check("done_cycle", cyc - c0, 2 * L);
      check("checksum", checksum, sum);
      check("we_count", we_cnt - we0, L);
      check("q_drained", exp_q.size(), 0);
      @(negedge clock);
      check("done_pulse", done, 0);
      check("busy_after", busy, 0);
      check("done_count", done_cnt - dn0, 1);
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] snap [16];
      int we0, dn0;
      for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
      repeat (3) @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_checksum", checksum, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_we", mem_we, 0);
      reset = 1'b0;
      @(negedge clock);

      // Forward copy
      run_copy(4'd0, 4'd8, 5'd4, 1'b0);
      for (int i = 0; i < 4; i++) check("fwd_mem", mem[8 + i], 8'(i + 1));
      check("fwd_cks", checksum, 8'd10);
      repeat (3) @(negedge clock);
      check("cks_hold", checksum, 8'd10);

      // Overlapping shift up: must run backward
      mem[2] = 8'hA; mem[3] = 8'hB; mem[4] = 8'hC; mem[5] = 8'hD;
      run_copy(4'd2, 4'd4, 5'd4, 1'b0);
      check("bwd_first_addr", wlog[wbase], 4'd7);
      check("bwd_mem4", mem[4], 8'hA);
      check("bwd_mem5", mem[5], 8'hB);
      check("bwd_mem6", mem[6], 8'hC);
      check("bwd_mem7", mem[7], 8'hD);
      check("bwd_src2", mem[2], 8'hA);
      check("bwd_src3", mem[3], 8'hB);

      // Wrap-around the top of memory
      mem[14] = 8'd5; mem[15] = 8'd6; mem[0] = 8'd7;
      run_copy(4'd14, 4'd1, 5'd3, 1'b0);
      check("wrap_mem1", mem[1], 8'd5);
      check("wrap_mem2", mem[2], 8'd6);
      check("wrap_mem3", mem[3], 8'd7);
      check("wrap_cks", checksum, 8'd18);

      // len=0 and clamped len=17 with src==dst
      snap = mem;
      run_copy(4'd0, 4'd0, 5'd0, 1'b0);
      check("len0_cks", checksum, 0);
      run_copy(4'd0, 4'd0, 5'd17, 1'b0);
      for (int i = 0; i < 16; i++) check("same_mem", mem[i], snap[i]);

      // start during a copy is ignored
      for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
      for (int i = 8; i < 12; i++) mem[i] = '0;
      run_copy(4'd0, 4'd8, 5'd4, 1'b1);
      for (int i = 0; i < 4; i++) check("mid_mem", mem[8 + i], 8'(i + 1));
      check("mid_cks", checksum, 8'd10);

      // Reset during the RD of word 2
      for (int i = 0; i < 4; i++) mem[i] = 8'(8'h21 + i);
      for (int i = 8; i < 12; i++) mem[i] = '0;
      exp_q.push_back('{addr: 4'd8, data: 8'h21});
      exp_q.push_back('{addr: 4'd9, data: 8'h22});
      we0   = we_cnt;
      dn0   = done_cnt;
      src   = 4'd0;
      dst   = 4'd8;
      len   = 5'd4;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("rstmid_busy", busy, 0);
      check("rstmid_we", mem_we, 0);
      check("rstmid_done", done, 0);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("rstmid_cks", checksum, 0);
      check("rstmid_done_count", done_cnt - dn0, 0);
      check("rstmid_we_count", we_cnt - we0, 2);
      check("rstmid_mem8", mem[8], 8'h21);
      check("rstmid_mem9", mem[9], 8'h22);
      check("rstmid_mem10", mem[10], 8'h00);
      check("rstmid_q", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
